dot_matrix_scanner: RTL and testbench

- Parametrised, double-buffered LED dot-matrix scan controller.
- Holds one ROWS-bit pattern per column in a front (displayed) and back (writable) buffer.
- Cycles the active column at a fixed dwell rate and drives that column's row pattern, with anti-ghosting blanking.
- Back-to-front buffer swaps occur only at frame boundaries. Sits between the pattern generator (elevator floor/arrow graphics) and the matrix pins.

---
 rtl/dot_matrix_scanner.sv | 154 +++++++++++++++
 tb/tb_dot_matrix_scanner.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_matrix_scanner.sv
// dot_matrix_scanner: double-buffered LED dot-matrix column scanner.
// Each column is active for DWELL clocks. The first BLANK clocks of every
// dwell force the rows off to suppress ghosting. After that the row pattern
// from the front buffer for that column is shown. Writes always go to the
// back buffer. A requested back/front exchange happens only at a frame
// boundary.
// Optional feature: define DOT_MATRIX_PWM_EN to add a 4-bit brightness input.
// The input gates the visible part of each dwell. It is sampled at column
// start.
module dot_matrix_scanner #(
  parameter int ROWS  = 8,
  parameter int COLS  = 16,
  parameter int DWELL = 1000,
  parameter int BLANK = 8,
  localparam int COL_W = $clog2(COLS),
  localparam int CNT_W = $clog2(DWELL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_col,
  input  logic [ROWS-1:0]  wr_data,
  input  logic             swap_req,
`ifdef DOT_MATRIX_PWM_EN
  input  logic [3:0]       brightness,
`endif
  output logic             swap_ack,
  output logic             frame_start,
  output logic [COL_W-1:0] col_sel,
  output logic [ROWS-1:0]  row_out
);

  typedef enum logic {PH_BLANK, PH_SHOW} phase_t;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
  localparam logic [COL_W:0]   COLS_EXT  = (COL_W + 1)'(COLS);
  localparam phase_t           PHASE_RST = (BLANK > 0) ? PH_BLANK : PH_SHOW;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             cnt_wrap;
  logic             frame_end;
  logic             do_swap;
  logic             blank_next;
  logic             buf_sel;   // index of the front (displayed) buffer
  logic             back_sel;
  logic             pending;
  logic             wr_ok;
  logic             pwm_on;
  phase_t           phase;

  logic [ROWS-1:0]  buf_mem [2][COLS];

  assign cnt_wrap  = (cnt == CNT_LAST);
  assign cnt_next  = cnt_wrap ? '0 : cnt + 1'b1;
  assign frame_end = cnt_wrap && (col_sel == COL_LAST);
  assign do_swap   = frame_end && (pending || swap_req);
  assign back_sel  = ~buf_sel;
  assign wr_ok     = wr_en && ({1'b0, wr_col} < COLS_EXT);

  // The phase for the next cycle depends on where the next count value lands.
  // With no blanking window the scanner is permanently in SHOW.
  generate
    if (BLANK == 0) begin : g_no_blank
      assign blank_next = 1'b0;
    end else begin : g_blank
      localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK);
      assign blank_next = (cnt_next < BLANK_CNT);
    end
  endgenerate

  // Scan sequencer: dwell counter, column index, phase, swap bookkeeping, pulses.
  // NOTE: state registers use non-blocking assignments. All of them then update
  // from the same pre-edge values, so the order of these statements does not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      col_sel     <= '0;
      phase       <= PHASE_RST;
      buf_sel     <= 1'b0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      phase       <= blank_next ? PH_BLANK : PH_SHOW;
      frame_start <= frame_end;
      swap_ack    <= do_swap;
      if (cnt_wrap) begin
        col_sel <= (col_sel == COL_LAST) ? '0 : col_sel + 1'b1;
      end
      if (do_swap) begin
        buf_sel <= ~buf_sel;
        pending <= 1'b0;
      end else if (swap_req) begin
        pending <= 1'b1;
      end
    end
  end

  // Pattern storage: writes land in the back buffer selected before this edge.
  // On a swap edge, that buffer becomes the front buffer.
  // NOTE: this storage is cleared by reset because it must power up dark.
  // That forces it into flops. A RAM macro could not be cleared this way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < COLS; c++) begin
        buf_mem[0][c] <= '0;
        buf_mem[1][c] <= '0;
      end
    end else if (wr_ok) begin
      buf_mem[back_sel][wr_col] <= wr_data;
    end
  end

`ifdef DOT_MATRIX_PWM_EN
  logic [3:0] bright_q;
  logic [3:0] bright_eff;
  int         show_idx;
  int         on_limit;

  // Latch the brightness at the first cycle of each column's dwell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bright_q <= '0;
    end else if (cnt == '0) begin
      bright_q <= brightness;
    end
  end

  assign bright_eff = (cnt == '0) ? brightness : bright_q;

  // Rows are lit for the first ((DWELL-BLANK)*(b+1))/16 cycles of SHOW.
  // NOTE: each variable assigned here gets a value on every path, which
  // keeps this block purely combinational (no inferred latch).
  always_comb begin
    show_idx = int'(cnt) - BLANK;
    on_limit = ((DWELL - BLANK) * (int'(bright_eff) + 1)) / 16;
    pwm_on   = (show_idx < on_limit);
  end
`else
  assign pwm_on = 1'b1;
`endif

  // Row drive: the active column's front pattern, only while visible.
  always_comb begin
    row_out = '0;
    if (phase == PH_SHOW && pwm_on) begin
      row_out = buf_mem[buf_sel][col_sel];
    end
  end

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Testbench for dot_matrix_scanner. It uses a time-indexed reference model:
// column and count come from the cycle number, and the buffers are modelled
// as two arrays that exchange contents on a swap.
module tb_dot_matrix_scanner;

  localparam int ROWS  = 8;
  localparam int COLS  = 4;
  localparam int BLANK = 1;
`ifdef DOT_MATRIX_PWM_EN
  localparam int DWELL = 17;
`else
  localparam int DWELL = 4;
`endif
  localparam int FRAME = COLS * DWELL;
  localparam int COL_W = $clog2(COLS);

  // Second instance with a non-power-of-two column count.
  // It can represent out-of-range column indices.
  localparam int O_COLS  = 5;
  localparam int O_DWELL = 2;
  localparam int O_COL_W = $clog2(O_COLS);
  localparam int O_FRAME = O_COLS * O_DWELL;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [COL_W-1:0] wr_col;
  logic [ROWS-1:0]  wr_data;
  logic             swap_req;
  logic             swap_ack;
  logic             frame_start;
  logic [COL_W-1:0] col_sel;
  logic [ROWS-1:0]  row_out;
`ifdef DOT_MATRIX_PWM_EN
  logic [3:0]       brightness;
`endif

  logic               o_wr_en;
  logic [O_COL_W-1:0] o_wr_col;
  logic [ROWS-1:0]    o_wr_data;
  logic               o_swap_req;
  logic               o_swap_ack;
  logic               o_frame_start;
  logic [O_COL_W-1:0] o_col_sel;
  logic [ROWS-1:0]    o_row_out;

  int tests_run;
  int tests_failed;

  dot_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_col(wr_col), .wr_data(wr_data),
    .swap_req(swap_req),
`ifdef DOT_MATRIX_PWM_EN
    .brightness(brightness),
`endif
    .swap_ack(swap_ack), .frame_start(frame_start), .col_sel(col_sel), .row_out(row_out)
  );

  dot_matrix_scanner #(.ROWS(ROWS), .COLS(O_COLS), .DWELL(O_DWELL), .BLANK(0)) u_odd (
    .clk(clk), .rst(rst), .wr_en(o_wr_en), .wr_col(o_wr_col), .wr_data(o_wr_data),
    .swap_req(o_swap_req),
`ifdef DOT_MATRIX_PWM_EN
    .brightness(4'hF),
`endif
    .swap_ack(o_swap_ack), .frame_start(o_frame_start), .col_sel(o_col_sel),
    .row_out(o_row_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int              t;            // cycles since reset release
  logic [ROWS-1:0] front_m [COLS];
  logic [ROWS-1:0] back_m  [COLS];
  bit              pend_m;
  bit              fs_m;
  bit              ack_m;
  int              m_bright;

  function automatic int exp_col();
    return (t / DWELL) % COLS;
  endfunction

  function automatic int exp_cnt();
    return t % DWELL;
  endfunction

  function automatic logic [ROWS-1:0] exp_row();
    int cnt;
    int b;
    cnt = exp_cnt();
    b   = m_bright;
    if (cnt < BLANK) return '0;
`ifdef DOT_MATRIX_PWM_EN
    if (cnt == 0) b = int'(brightness);
    if ((cnt - BLANK) >= ((DWELL - BLANK) * (b + 1)) / 16) return '0;
`endif
    return front_m[exp_col()];
  endfunction

  task automatic model_reset();
    t = 0;
    for (int c = 0; c < COLS; c++) begin
      front_m[c] = '0;
      back_m[c]  = '0;
    end
    pend_m   = 1'b0;
    fs_m     = 1'b0;
    ack_m    = 1'b0;
    m_bright = 15;
  endtask

  // Applies one clock edge to the model using the inputs present at that edge.
  task automatic model_edge();
    logic [ROWS-1:0] tmp;
    bit fe;
    bit sw;
    fe = (exp_cnt() == DWELL - 1) && (exp_col() == COLS - 1);
    sw = fe && (pend_m || swap_req);
`ifdef DOT_MATRIX_PWM_EN
    if (exp_cnt() == 0) m_bright = int'(brightness);
`endif
    if (wr_en && int'(wr_col) < COLS) back_m[wr_col] = wr_data;
    if (sw) begin
      for (int c = 0; c < COLS; c++) begin
        tmp        = front_m[c];
        front_m[c] = back_m[c];
        back_m[c]  = tmp;
      end
    end
    if (sw) pend_m = 1'b0;
    else if (swap_req) pend_m = 1'b1;
    fs_m  = fe;
    ack_m = sw;
    t++;
  endtask

  // Inputs change at negedge; the model steps at posedge; outputs are read at the next negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Loads every back column with v, then swaps so v becomes the front pattern.
  task automatic load_front(input logic [ROWS-1:0] v);
    for (int c = 0; c < COLS; c++) begin
      wr_en = 1'b1; wr_col = COL_W'(c); wr_data = v;
      tick();
    end
    wr_en    = 1'b0;
    swap_req = 1'b1;
    for (int i = 0; i < 2 * FRAME && !ack_m; i++) tick();
    swap_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tests_run++;
    if (col_sel !== '0) begin tests_failed++; $display("FAIL reset_col got %0d want 0", col_sel); end
    tests_run++;
    if (row_out !== '0) begin tests_failed++; $display("FAIL reset_row got %h want 00", row_out); end
    tests_run++;
    if (frame_start !== 1'b0) begin tests_failed++; $display("FAIL reset_fs got %b want 0", frame_start); end
    tests_run++;
    if (swap_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack got %b want 0", swap_ack); end
  endtask

  task automatic test_idle();
    int first_fs;
    first_fs = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tests_run++;
      if (col_sel !== COL_W'(exp_col())) begin
        tests_failed++; $display("FAIL idle_col t=%0d got %0d want %0d", t, col_sel, exp_col());
      end
      tests_run++;
      if (row_out !== '0) begin
        tests_failed++; $display("FAIL idle_row t=%0d got %h want 00", t, row_out);
      end
      tests_run++;
      if (frame_start !== fs_m) begin
        tests_failed++; $display("FAIL idle_fs t=%0d got %b want %b", t, frame_start, fs_m);
      end
      tests_run++;
      if (swap_ack !== 1'b0) begin
        tests_failed++; $display("FAIL idle_ack t=%0d got %b want 0", t, swap_ack);
      end
      if (frame_start === 1'b1 && first_fs < 0) first_fs = i;
      tick();
    end
    tests_run++;
    if (first_fs != FRAME) begin
      tests_failed++; $display("FAIL idle_first_fs got %0d want %0d", first_fs, FRAME);
    end
  endtask

  task automatic test_write_no_swap();
    logic [ROWS-1:0] vals [4];
    vals[0] = 8'hA5; vals[1] = 8'h3C; vals[2] = 8'hFF; vals[3] = 8'h01;
    for (int c = 0; c < COLS; c++) begin
      wr_en = 1'b1; wr_col = COL_W'(c); wr_data = vals[c];
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tests_run++;
      if (row_out !== '0) begin
        tests_failed++; $display("FAIL noswap_row t=%0d got %h want 00", t, row_out);
      end
      tick();
    end
  endtask

  task automatic test_swap();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < FRAME && (t % FRAME) != FRAME / 2; i++) tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      tests_run++;
      if (swap_ack !== ack_m) begin
        tests_failed++; $display("FAIL swap_ack t=%0d got %b want %b", t, swap_ack, ack_m);
      end
      if (ack_m) begin
        seen = 1'b1;
        tests_run++;
        if (frame_start !== 1'b1) begin
          tests_failed++; $display("FAIL swap_fs_coincident got %b want 1", frame_start);
        end
      end else begin
        tick();
      end
    end
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL swap_timeout got no ack want ack"); end
    for (int i = 0; i < FRAME; i++) begin
      tests_run++;
      if (col_sel !== COL_W'(exp_col()) || row_out !== exp_row()) begin
        tests_failed++;
        $display("FAIL swap_show t=%0d got col %0d row %h want col %0d row %h",
                 t, col_sel, row_out, exp_col(), exp_row());
      end
      if (exp_col() == 2) begin
        tests_run++;
        if (row_out !== ((exp_cnt() < BLANK) ? 8'h00 : 8'hFF)) begin
          tests_failed++; $display("FAIL swap_col2 cnt=%0d got %h want %h", exp_cnt(), row_out,
                                   (exp_cnt() < BLANK) ? 8'h00 : 8'hFF);
        end
      end
      tick();
    end
  endtask

  task automatic test_swap_edge_write();
    for (int i = 0; i < FRAME && (t % FRAME) != FRAME - 1; i++) tick();
    swap_req = 1'b1; wr_en = 1'b1; wr_col = COL_W'(2); wr_data = 8'h81;
    tick();
    swap_req = 1'b0; wr_en = 1'b0;
    tests_run++;
    if (swap_ack !== 1'b1) begin tests_failed++; $display("FAIL edge_ack got %b want 1", swap_ack); end
    for (int i = 0; i < FRAME; i++) begin
      tests_run++;
      if (row_out !== exp_row()) begin
        tests_failed++; $display("FAIL edge_row t=%0d got %h want %h", t, row_out, exp_row());
      end
      if (exp_col() == 2 && exp_cnt() >= BLANK) begin
        tests_run++;
        if (row_out !== 8'h81) begin
          tests_failed++; $display("FAIL edge_col2 got %h want 81", row_out);
        end
      end
      tick();
    end
  endtask

  task automatic test_bad_col();
    bit seen;
    int o;
    seen = 1'b0;
    for (int c = 5; c < 8; c++) begin
      o_wr_en = 1'b1; o_wr_col = O_COL_W'(c); o_wr_data = 8'hFF;
      @(negedge clk);
    end
    o_wr_col = O_COL_W'(4); o_wr_data = 8'h5A;
    @(negedge clk);
    o_wr_en    = 1'b0;
    o_swap_req = 1'b1;
    @(negedge clk);
    o_swap_req = 1'b0;
    for (int i = 0; i < 3 * O_FRAME && !seen; i++) begin
      if (o_swap_ack === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL badcol_timeout got no ack want ack"); end
    for (o = 0; o < 2 * O_FRAME; o++) begin
      tests_run++;
      if (o_col_sel !== O_COL_W'((o / O_DWELL) % O_COLS) ||
          o_row_out !== ((((o / O_DWELL) % O_COLS) == 4) ? 8'h5A : 8'h00)) begin
        tests_failed++;
        $display("FAIL badcol_show o=%0d got col %0d row %h want col %0d row %h", o, o_col_sel,
                 o_row_out, (o / O_DWELL) % O_COLS, (((o / O_DWELL) % O_COLS) == 4) ? 8'h5A : 8'h00);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20 * FRAME; i++) begin
      tests_run++;
      if (col_sel !== COL_W'(exp_col()) || row_out !== exp_row() ||
          frame_start !== fs_m || swap_ack !== ack_m) begin
        tests_failed++;
        $display("FAIL rand t=%0d got col %0d row %h fs %b ack %b want col %0d row %h fs %b ack %b",
                 t, col_sel, row_out, frame_start, swap_ack, exp_col(), exp_row(), fs_m, ack_m);
      end
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_col   = COL_W'($urandom_range(0, COLS - 1));
      wr_data  = ROWS'($urandom);
      swap_req = ($urandom_range(0, 15) == 0);
`ifdef DOT_MATRIX_PWM_EN
      if ($urandom_range(0, 4) == 0) brightness = 4'($urandom);
`endif
      tick();
    end
    wr_en = 1'b0; swap_req = 1'b0;
`ifdef DOT_MATRIX_PWM_EN
    brightness = 4'hF;
`endif
  endtask

  task automatic test_back_to_back();
    int acks;
    acks = 0;
    swap_req = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (swap_ack === 1'b1) acks++;
      tests_run++;
      if (row_out !== exp_row() || swap_ack !== ack_m) begin
        tests_failed++;
        $display("FAIL b2b t=%0d got row %h ack %b want row %h ack %b", t, row_out, swap_ack,
                 exp_row(), ack_m);
      end
    end
    swap_req = 1'b0;
    tests_run++;
    if (acks != 3) begin tests_failed++; $display("FAIL b2b_count got %0d want 3", acks); end
    for (int i = 0; i < 2 * FRAME; i++) tick();
  endtask

  task automatic test_reset_midframe();
    load_front(8'hFF);
    for (int i = 0; i < 2 * FRAME && !(exp_col() == 1 && exp_cnt() == 0); i++) tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tests_run++;
    if (row_out !== 8'hFF) begin tests_failed++; $display("FAIL prerst_row got %h want FF", row_out); end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (col_sel !== '0 || row_out !== '0 || frame_start !== 1'b0 || swap_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_outputs got col %0d row %h fs %b ack %b want all 0",
               col_sel, row_out, frame_start, swap_ack);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < FRAME + 2; i++) begin
      tests_run++;
      if (swap_ack !== 1'b0 || row_out !== '0 || col_sel !== COL_W'(exp_col()) ||
          frame_start !== fs_m) begin
        tests_failed++;
        $display("FAIL postrst t=%0d got col %0d row %h fs %b ack %b want col %0d row 00 fs %b ack 0",
                 t, col_sel, row_out, frame_start, swap_ack, exp_col(), fs_m);
      end
      tick();
    end
  endtask

`ifdef DOT_MATRIX_PWM_EN
  task automatic test_pwm();
    int lit;
    int want;
    load_front(8'hFF);
    for (int k = 0; k < 2; k++) begin
      brightness = (k == 0) ? 4'd3 : 4'd15;
      want       = (k == 0) ? 4 : 16;
      for (int i = 0; i < DWELL && exp_cnt() != 0; i++) tick();
      lit = 0;
      for (int i = 0; i < DWELL; i++) begin
        if (row_out !== '0) lit++;
        tests_run++;
        if (row_out !== exp_row()) begin
          tests_failed++; $display("FAIL pwm_row t=%0d got %h want %h", t, row_out, exp_row());
        end
        tick();
      end
      tests_run++;
      if (lit != want) begin
        tests_failed++; $display("FAIL pwm_lit b=%0d got %0d want %0d", brightness, lit, want);
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; wr_en = 1'b0; wr_col = '0; wr_data = '0; swap_req = 1'b0;
    o_wr_en = 1'b0; o_wr_col = '0; o_wr_data = '0; o_swap_req = 1'b0;
`ifdef DOT_MATRIX_PWM_EN
    brightness = 4'hF;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_idle();
    test_write_no_swap();
    test_swap();
    test_swap_edge_write();
    test_bad_col();
    test_random();
    test_back_to_back();
    test_reset_midframe();
`ifdef DOT_MATRIX_PWM_EN
    test_pwm();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
